// File: rtl/risc_issue_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : risc_issue_sequencer_pkg
// Purpose  : Shared types and constants for the RISC issue sequencer:
//            ALU operation codes (arithmetic plus branch compares),
//            instruction classes, opcode/funct encodings and the decoder.
// Revision : 1.0 - initial release
// ============================================================================
package risc_issue_sequencer_pkg;

    typedef enum logic [3:0] {
        ALU_ADD          = 4'd0,
        ALU_SUBTRACT     = 4'd1,
        ALU_XOR          = 4'd2,
        ALU_OR           = 4'd3,
        ALU_AND          = 4'd4,
        ALU_SHIFT_LT_LOG = 4'd5,
        ALU_SHIFT_RT_LOG = 4'd6,
        ALU_SHIFT_RT_AR  = 4'd7,
        ALU_BEQ          = 4'd8,
        ALU_BNE          = 4'd9,
        ALU_BLT          = 4'd10,
        ALU_BGE          = 4'd11,
        ALU_BLTU         = 4'd12,
        ALU_BGEU         = 4'd13
    } alu_op_code_t;

    typedef enum logic [2:0] {
        INSTR_R       = 3'd0,
        INSTR_I       = 3'd1,
        INSTR_S       = 3'd2,
        INSTR_B       = 3'd3,
        INSTR_ILLEGAL = 3'd4
    } risc_instr_type_t;

    localparam logic [6:0] c_OPC_R    = 7'b0110011;
    localparam logic [6:0] c_OPC_I    = 7'b0010011;
    localparam logic [6:0] c_OPC_S    = 7'b0100011;
    localparam logic [6:0] c_OPC_B    = 7'b1100011;

    localparam logic [6:0] c_F7_BASE  = 7'b0000000;
    localparam logic [6:0] c_F7_ALT   = 7'b0100000;

    localparam logic [2:0] c_F3_ADD   = 3'b000;
    localparam logic [2:0] c_F3_SLL   = 3'b001;
    localparam logic [2:0] c_F3_XOR   = 3'b100;
    localparam logic [2:0] c_F3_SR    = 3'b101;
    localparam logic [2:0] c_F3_OR    = 3'b110;
    localparam logic [2:0] c_F3_AND   = 3'b111;

    localparam logic [2:0] c_F3_BEQ   = 3'b000;
    localparam logic [2:0] c_F3_BNE   = 3'b001;
    localparam logic [2:0] c_F3_BLT   = 3'b100;
    localparam logic [2:0] c_F3_BGE   = 3'b101;
    localparam logic [2:0] c_F3_BLTU  = 3'b110;
    localparam logic [2:0] c_F3_BGEU  = 3'b111;

    typedef struct packed {
        logic             illegal;
        risc_instr_type_t itype;
        alu_op_code_t     op;
    } decode_t;

    // Classify an instruction and pick its ALU operation. Anything that does
    // not map onto an ALU_OP_CODE comes back flagged illegal.
    function automatic decode_t decode_instr(input logic [31:0] instr);
        decode_t    d;
        logic [6:0] f7;
        logic [2:0] f3;
        f7        = instr[31:25];
        f3        = instr[14:12];
        d.illegal = 1'b0;
        d.itype   = INSTR_ILLEGAL;
        d.op      = ALU_ADD;
        case (instr[6:0])
            c_OPC_R: begin
                d.itype = INSTR_R;
                case ({f7, f3})
                    {c_F7_BASE, c_F3_ADD}: d.op = ALU_ADD;
                    {c_F7_ALT,  c_F3_ADD}: d.op = ALU_SUBTRACT;
                    {c_F7_BASE, c_F3_XOR}: d.op = ALU_XOR;
                    {c_F7_BASE, c_F3_OR }: d.op = ALU_OR;
                    {c_F7_BASE, c_F3_AND}: d.op = ALU_AND;
                    {c_F7_BASE, c_F3_SLL}: d.op = ALU_SHIFT_LT_LOG;
                    {c_F7_BASE, c_F3_SR }: d.op = ALU_SHIFT_RT_LOG;
                    {c_F7_ALT,  c_F3_SR }: d.op = ALU_SHIFT_RT_AR;
                    default:               d.illegal = 1'b1;
                endcase
            end
            c_OPC_I: begin
                d.itype = INSTR_I;
                case (f3)
                    c_F3_ADD: d.op = ALU_ADD;
                    c_F3_XOR: d.op = ALU_XOR;
                    c_F3_OR:  d.op = ALU_OR;
                    c_F3_AND: d.op = ALU_AND;
                    c_F3_SLL: begin
                        if (f7 == c_F7_BASE) d.op = ALU_SHIFT_LT_LOG;
                        else                 d.illegal = 1'b1;
                    end
                    c_F3_SR: begin
                        if (f7 == c_F7_BASE)     d.op = ALU_SHIFT_RT_LOG;
                        else if (f7 == c_F7_ALT) d.op = ALU_SHIFT_RT_AR;
                        else                     d.illegal = 1'b1;
                    end
                    default: d.illegal = 1'b1;
                endcase
            end
            c_OPC_S: begin
                d.itype = INSTR_S;
                d.op    = ALU_ADD;
            end
            c_OPC_B: begin
                d.itype = INSTR_B;
                case (f3)
                    c_F3_BEQ:  d.op = ALU_BEQ;
                    c_F3_BNE:  d.op = ALU_BNE;
                    c_F3_BLT:  d.op = ALU_BLT;
                    c_F3_BGE:  d.op = ALU_BGE;
                    c_F3_BLTU: d.op = ALU_BLTU;
                    c_F3_BGEU: d.op = ALU_BGEU;
                    default:   d.illegal = 1'b1;
                endcase
            end
            default: d.illegal = 1'b1;
        endcase
        if (d.illegal) begin
            d.itype = INSTR_ILLEGAL;
            d.op    = ALU_ADD;
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/risc_imm_gen.sv
`default_nettype none
// ============================================================================
// Module   : risc_imm_gen
// Purpose  : Combinational immediate extraction with sign extension.
// Ports    : instr  - 32-bit instruction word
//            imm_i  - I-type immediate, sign-extended to XLEN
//            imm_s  - S-type immediate, sign-extended to XLEN
//            imm_b  - B-type 13-bit byte offset, sign-extended to XLEN
// Revision : 1.0 - initial release
// ============================================================================
module risc_imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_s,
    output logic [XLEN-1:0] imm_b
);

    // Register-index and opcode fields carry no immediate bits.
    logic w_unused;
    assign w_unused = ^{instr[19:12], instr[6:0]};

    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};

endmodule
`default_nettype wire

// File: rtl/risc_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : risc_issue_sequencer
// Purpose  : Fetch / decode / operand-read / issue sequencer for a small
//            RISC-V subset (R, I-ALU, S, B). One instruction in flight.
// Ports    : clk, reset_n (async, active low)
//            mem_rd_*        instruction fetch request / data / ack
//            reg_rd_*_a/_b   rs1 / rs2 read requests / data / acks
//            alu_*           issue bundle, handshake, completion, branch PC
//            illegal_instr   one-cycle pulse on an undecodable instruction
//            pc              current program counter
// Revision : 1.0 - initial release
// ============================================================================
module risc_issue_sequencer
    import risc_issue_sequencer_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int PC_STEP = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic [XLEN-1:0] mem_rd_addr,
    output logic            mem_rd_addr_valid,
    input  logic [31:0]     mem_rd_data,
    input  logic            mem_rd_ack,
    output logic [4:0]      reg_rd_addr_a,
    output logic            reg_rd_addr_a_valid,
    input  logic [XLEN-1:0] reg_rd_data_a,
    input  logic            reg_rd_data_a_ack,
    output logic [4:0]      reg_rd_addr_b,
    output logic            reg_rd_addr_b_valid,
    input  logic [XLEN-1:0] reg_rd_data_b,
    input  logic            reg_rd_data_b_ack,
    output alu_op_code_t    alu_op_code,
    output logic [XLEN-1:0] alu_input_A,
    output logic [XLEN-1:0] alu_input_B,
    output logic            alu_reg_out,
    output logic [4:0]      alu_reg_addr,
    output logic            alu_mem_out,
    output logic [XLEN-1:0] alu_mem_addr,
    output logic            alu_pc_jump,
    output logic            alu_inputs_valid,
    input  logic            alu_input_ack,
    input  logic            alu_done,
    input  logic [XLEN-1:0] alu_pc_branch_data,
    input  logic            alu_pc_branch_data_valid,
    output logic            alu_pc_branch_data_ack,
    output logic            illegal_instr,
    output logic [XLEN-1:0] pc
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_REG_RD    = 3'd2;
    localparam logic [2:0] S_ISSUE     = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_BR_WAIT   = 3'd5;

    localparam logic [XLEN-1:0] c_PC_INC = XLEN'(PC_STEP);

    logic [2:0]       r_state;
    logic [XLEN-1:0]  r_pc;
    logic             r_mem_valid;
    logic [31:0]      r_instr;
    risc_instr_type_t r_type;
    alu_op_code_t     r_op;
    logic             r_illegal;
    logic             r_a_valid, r_b_valid;
    logic             r_a_seen,  r_b_seen;
    logic [XLEN-1:0]  r_a_data,  r_b_data;
    logic             r_alu_valid;
    alu_op_code_t     r_alu_op;
    logic [XLEN-1:0]  r_alu_a, r_alu_b, r_alu_mem_addr;
    logic             r_alu_reg_out, r_alu_mem_out, r_alu_jump;
    logic [4:0]       r_alu_reg_addr;
    logic             r_br_ack;

    decode_t          w_dec;
    logic [XLEN-1:0]  w_imm_i, w_imm_s, w_imm_b, w_br_off;
    logic [XLEN-1:0]  w_nxt_a, w_nxt_b, w_nxt_mem_addr;
    logic             w_nxt_reg_out, w_nxt_mem_out, w_nxt_jump;

    assign w_dec = decode_instr(mem_rd_data);

    risc_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (r_instr),
        .imm_i (w_imm_i),
        .imm_s (w_imm_s),
        .imm_b (w_imm_b)
    );

    // Branch offsets are encoded in bytes; a word-addressed PC needs them
    // scaled down, keeping the sign.
    generate
        if (PC_STEP == 4) begin : g_byte_pc
            assign w_br_off = w_imm_b;
        end else begin : g_word_pc
            logic signed [XLEN-1:0] w_imm_b_s;
            assign w_imm_b_s = w_imm_b;
            assign w_br_off  = w_imm_b_s >>> 2;
        end
    endgenerate

    // Issue bundle assembled from the latched operands.
    always_comb begin
        w_nxt_a        = r_a_data;
        w_nxt_b        = r_b_data;
        w_nxt_reg_out  = 1'b0;
        w_nxt_mem_out  = 1'b0;
        w_nxt_jump     = 1'b0;
        w_nxt_mem_addr = '0;
        case (r_type)
            INSTR_R: w_nxt_reg_out = 1'b1;
            INSTR_I: begin
                w_nxt_b       = w_imm_i;
                w_nxt_reg_out = 1'b1;
            end
            INSTR_S: begin
                // Store data travels through the ALU as rs2 + 0.
                w_nxt_a        = r_b_data;
                w_nxt_b        = '0;
                w_nxt_mem_out  = 1'b1;
                w_nxt_mem_addr = r_a_data + w_imm_s;
            end
            INSTR_B: begin
                w_nxt_jump     = 1'b1;
                w_nxt_mem_addr = r_pc + w_br_off;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_pc           <= '0;
            r_mem_valid    <= 1'b0;
            r_instr        <= '0;
            r_type         <= INSTR_R;
            r_op           <= ALU_ADD;
            r_illegal      <= 1'b0;
            r_a_valid      <= 1'b0;
            r_b_valid      <= 1'b0;
            r_a_seen       <= 1'b0;
            r_b_seen       <= 1'b0;
            r_a_data       <= '0;
            r_b_data       <= '0;
            r_alu_valid    <= 1'b0;
            r_alu_op       <= ALU_ADD;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_reg_out  <= 1'b0;
            r_alu_reg_addr <= '0;
            r_alu_mem_out  <= 1'b0;
            r_alu_mem_addr <= '0;
            r_alu_jump     <= 1'b0;
            r_br_ack       <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            r_br_ack  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state     <= S_FETCH;
                    r_mem_valid <= 1'b1;
                end
                S_FETCH: begin
                    if (!r_mem_valid) begin
                        // Re-request after an illegal instruction, leaving
                        // one low cycle after the previous ack.
                        r_mem_valid <= 1'b1;
                    end else if (mem_rd_ack) begin
                        r_mem_valid <= 1'b0;
                        r_instr     <= mem_rd_data;
                        r_type      <= w_dec.itype;
                        r_op        <= w_dec.op;
                        if (w_dec.illegal) begin
                            r_illegal <= 1'b1;
                            r_pc      <= r_pc + c_PC_INC;
                        end else begin
                            r_state   <= S_REG_RD;
                            r_a_valid <= 1'b1;
                            r_a_seen  <= 1'b0;
                            // I-type has no rs2: mark it as already seen.
                            r_b_valid <= (w_dec.itype != INSTR_I);
                            r_b_seen  <= (w_dec.itype == INSTR_I);
                        end
                    end
                end
                S_REG_RD: begin
                    if (r_a_valid && reg_rd_data_a_ack) begin
                        r_a_data  <= reg_rd_data_a;
                        r_a_seen  <= 1'b1;
                        r_a_valid <= 1'b0;
                    end
                    if (r_b_valid && reg_rd_data_b_ack) begin
                        r_b_data  <= reg_rd_data_b;
                        r_b_seen  <= 1'b1;
                        r_b_valid <= 1'b0;
                    end
                    if (r_a_seen && r_b_seen) begin
                        r_state        <= S_ISSUE;
                        r_alu_valid    <= 1'b1;
                        r_alu_op       <= r_op;
                        r_alu_a        <= w_nxt_a;
                        r_alu_b        <= w_nxt_b;
                        r_alu_reg_out  <= w_nxt_reg_out;
                        r_alu_reg_addr <= w_nxt_reg_out ? r_instr[11:7] : 5'd0;
                        r_alu_mem_out  <= w_nxt_mem_out;
                        r_alu_mem_addr <= w_nxt_mem_addr;
                        r_alu_jump     <= w_nxt_jump;
                    end
                end
                S_ISSUE: begin
                    if (alu_input_ack) begin
                        r_alu_valid <= 1'b0;
                        if (r_type == INSTR_B) begin
                            r_state <= S_BR_WAIT;
                        end else begin
                            r_pc    <= r_pc + c_PC_INC;
                            r_state <= S_WAIT_DONE;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (alu_done) begin
                        r_state     <= S_FETCH;
                        r_mem_valid <= 1'b1;
                    end
                end
                S_BR_WAIT: begin
                    if (alu_pc_branch_data_valid) begin
                        r_pc        <= alu_pc_branch_data;
                        r_br_ack    <= 1'b1;
                        r_state     <= S_FETCH;
                        r_mem_valid <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pc                     = r_pc;
    assign mem_rd_addr            = r_pc;
    assign mem_rd_addr_valid      = r_mem_valid;
    assign reg_rd_addr_a          = r_instr[19:15];
    assign reg_rd_addr_a_valid    = r_a_valid;
    assign reg_rd_addr_b          = r_instr[24:20];
    assign reg_rd_addr_b_valid    = r_b_valid;
    assign alu_op_code            = r_alu_op;
    assign alu_input_A            = r_alu_a;
    assign alu_input_B            = r_alu_b;
    assign alu_reg_out            = r_alu_reg_out;
    assign alu_reg_addr           = r_alu_reg_addr;
    assign alu_mem_out            = r_alu_mem_out;
    assign alu_mem_addr           = r_alu_mem_addr;
    assign alu_pc_jump            = r_alu_jump;
    assign alu_inputs_valid       = r_alu_valid;
    assign alu_pc_branch_data_ack = r_br_ack;
    assign illegal_instr          = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_risc_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_risc_issue_sequencer
// Purpose  : Self-checking bench for risc_issue_sequencer (XLEN=32,
//            word-addressed PC). Expected issue bundles are queued as each
//            instruction is fed and compared when the DUT raises
//            alu_inputs_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_risc_issue_sequencer;
    import risc_issue_sequencer_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [31:0]  mem_rd_addr;
    logic         mem_rd_addr_valid;
    logic [31:0]  mem_rd_data = '0;
    logic         mem_rd_ack = 1'b0;
    logic [4:0]   reg_rd_addr_a, reg_rd_addr_b;
    logic         reg_rd_addr_a_valid, reg_rd_addr_b_valid;
    logic [31:0]  reg_rd_data_a = '0, reg_rd_data_b = '0;
    logic         reg_rd_data_a_ack = 1'b0, reg_rd_data_b_ack = 1'b0;
    alu_op_code_t alu_op_code;
    logic [31:0]  alu_input_A, alu_input_B, alu_mem_addr;
    logic         alu_reg_out, alu_mem_out, alu_pc_jump, alu_inputs_valid;
    logic [4:0]   alu_reg_addr;
    logic         alu_input_ack = 1'b0, alu_done = 1'b0;
    logic [31:0]  alu_pc_branch_data = '0;
    logic         alu_pc_branch_data_valid = 1'b0;
    logic         alu_pc_branch_data_ack, illegal_instr;
    logic [31:0]  pc;

    always #5 clk = ~clk;

    risc_issue_sequencer #(.XLEN(32), .PC_STEP(1)) dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .mem_rd_addr              (mem_rd_addr),
        .mem_rd_addr_valid        (mem_rd_addr_valid),
        .mem_rd_data              (mem_rd_data),
        .mem_rd_ack               (mem_rd_ack),
        .reg_rd_addr_a            (reg_rd_addr_a),
        .reg_rd_addr_a_valid      (reg_rd_addr_a_valid),
        .reg_rd_data_a            (reg_rd_data_a),
        .reg_rd_data_a_ack        (reg_rd_data_a_ack),
        .reg_rd_addr_b            (reg_rd_addr_b),
        .reg_rd_addr_b_valid      (reg_rd_addr_b_valid),
        .reg_rd_data_b            (reg_rd_data_b),
        .reg_rd_data_b_ack        (reg_rd_data_b_ack),
        .alu_op_code              (alu_op_code),
        .alu_input_A              (alu_input_A),
        .alu_input_B              (alu_input_B),
        .alu_reg_out              (alu_reg_out),
        .alu_reg_addr             (alu_reg_addr),
        .alu_mem_out              (alu_mem_out),
        .alu_mem_addr             (alu_mem_addr),
        .alu_pc_jump              (alu_pc_jump),
        .alu_inputs_valid         (alu_inputs_valid),
        .alu_input_ack            (alu_input_ack),
        .alu_done                 (alu_done),
        .alu_pc_branch_data       (alu_pc_branch_data),
        .alu_pc_branch_data_valid (alu_pc_branch_data_valid),
        .alu_pc_branch_data_ack   (alu_pc_branch_data_ack),
        .illegal_instr            (illegal_instr),
        .pc                       (pc)
    );

    typedef struct {
        alu_op_code_t op;
        logic [31:0]  a;
        logic [31:0]  b;
        logic         reg_out;
        logic [4:0]   reg_addr;
        logic         mem_out;
        logic [31:0]  mem_addr;
        logic         jump;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] regs [32];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic sig_sel(input int which);
        case (which)
            0:       return mem_rd_addr_valid;
            1:       return reg_rd_addr_a_valid;
            default: return alu_inputs_valid;
        endcase
    endfunction

    // Bounded wait at negedges for a request line to go high.
    task automatic wait_for(input int which, input string tag);
        int n = 0;
        while (!sig_sel(which) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_seen"}, {31'b0, sig_sel(which)}, 32'd1);
    endtask

    task automatic push_exp(input alu_op_code_t op, input logic [31:0] a, b,
                            input logic ro, input logic [4:0] ra,
                            input logic mo, input logic [31:0] ma, input logic j);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.reg_out = ro; e.reg_addr = ra;
        e.mem_out = mo; e.mem_addr = ma; e.jump = j;
        exp_q.push_back(e);
    endtask

    task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] instr);
        wait_for(0, "fetch_req");
        check("fetch_addr", mem_rd_addr, exp_pc);
        mem_rd_data = instr;
        mem_rd_ack  = 1'b1;
        @(negedge clk);
        mem_rd_ack  = 1'b0;
        mem_rd_data = '0;
        check("fetch_valid_drop", {31'b0, mem_rd_addr_valid}, 32'd0);
    endtask

    // Register-file responder: a-ack at cycle da, b-ack at cycle db.
    // With inject set, stray ALU completion/branch inputs are driven while
    // operands are still being read; they must have no effect.
    task automatic do_regs(input logic [4:0] rs1, input logic [4:0] rs2, input bit need_b,
                           input int da, input int db, input bit inject);
        wait_for(1, "rd_a_req");
        if (!need_b) check("b_not_requested", {31'b0, reg_rd_addr_b_valid}, 32'd0);
        for (int t = 0; t < 6; t++) begin
            reg_rd_data_a_ack = (t == da);
            reg_rd_data_a     = regs[reg_rd_addr_a];
            if (t == da)     check("rs1_addr", {27'b0, reg_rd_addr_a}, {27'b0, rs1});
            if (t == da + 1) check("a_valid_drop", {31'b0, reg_rd_addr_a_valid}, 32'd0);
            if (need_b) begin
                reg_rd_data_b_ack = (t == db);
                reg_rd_data_b     = regs[reg_rd_addr_b];
                if (t == db) begin
                    check("rs2_addr", {27'b0, reg_rd_addr_b}, {27'b0, rs2});
                    check("b_valid_hold", {31'b0, reg_rd_addr_b_valid}, 32'd1);
                end
                if (t == db + 1) check("b_valid_drop", {31'b0, reg_rd_addr_b_valid}, 32'd0);
            end
            alu_done                 = inject && (t == 1);
            alu_pc_branch_data_valid = inject && (t == 1);
            alu_pc_branch_data       = 32'h55;
            @(negedge clk);
        end
        reg_rd_data_a_ack        = 1'b0;
        reg_rd_data_b_ack        = 1'b0;
        alu_done                 = 1'b0;
        alu_pc_branch_data_valid = 1'b0;
    endtask

    task automatic do_issue(input logic [31:0] pc_after, input bit is_br, input logic [31:0] target);
        exp_t e;
        wait_for(2, "issue");
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check("alu_op",       alu_op_code,            e.op);
        check("alu_A",        alu_input_A,            e.a);
        check("alu_B",        alu_input_B,            e.b);
        check("alu_reg_out",  {31'b0, alu_reg_out},   {31'b0, e.reg_out});
        check("alu_reg_addr", {27'b0, alu_reg_addr},  {27'b0, e.reg_addr});
        check("alu_mem_out",  {31'b0, alu_mem_out},   {31'b0, e.mem_out});
        check("alu_mem_addr", alu_mem_addr,           e.mem_addr);
        check("alu_pc_jump",  {31'b0, alu_pc_jump},   {31'b0, e.jump});
        // Hold off the ack one cycle: the bundle must stay put.
        @(negedge clk);
        check("issue_stable_A", alu_input_A, e.a);
        alu_input_ack = 1'b1;
        @(negedge clk);
        alu_input_ack = 1'b0;
        check("issue_valid_drop", {31'b0, alu_inputs_valid}, 32'd0);
        check("pc_after_ack", pc, pc_after);
        if (!is_br) begin
            @(negedge clk);
            check("issue_once", {31'b0, alu_inputs_valid}, 32'd0);
            alu_done = 1'b1;
            @(negedge clk);
            alu_done = 1'b0;
        end else begin
            @(negedge clk);
            alu_pc_branch_data       = target;
            alu_pc_branch_data_valid = 1'b1;
            @(negedge clk);
            alu_pc_branch_data_valid = 1'b0;
            check("br_ack_high", {31'b0, alu_pc_branch_data_ack}, 32'd1);
            check("br_pc", pc, target);
            @(negedge clk);
            check("br_ack_pulse", {31'b0, alu_pc_branch_data_ack}, 32'd0);
        end
    endtask

    task automatic expect_illegal();
        check("illegal_pulse", {31'b0, illegal_instr}, 32'd1);
        check("illegal_no_rd", {31'b0, reg_rd_addr_a_valid}, 32'd0);
        @(negedge clk);
        check("illegal_clear", {31'b0, illegal_instr}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pc",        pc, 32'd0);
        check("rst_mem_valid", {31'b0, mem_rd_addr_valid}, 32'd0);
        check("rst_issue",     {31'b0, alu_inputs_valid}, 32'd0);
        check("rst_op",        alu_op_code, ALU_ADD);
        check("rst_illegal",   {31'b0, illegal_instr}, 32'd0);
        reset_n = 1'b1;
        #1;
        check("idle_cycle", {31'b0, mem_rd_addr_valid}, 32'd0);
        @(negedge clk);

        // ADD x3,x1,x2
        regs[1] = 32'd5; regs[2] = 32'd7;
        push_exp(ALU_ADD, 32'd5, 32'd7, 1'b1, 5'd3, 1'b0, 32'd0, 1'b0);
        do_fetch(32'd0, 32'h002081B3);
        do_regs(5'd1, 5'd2, 1'b1, 0, 0, 1'b0);
        do_issue(32'd1, 1'b0, 32'd0);

        // ADDI x4,x1,-1
        push_exp(ALU_ADD, 32'd5, 32'hFFFF_FFFF, 1'b1, 5'd4, 1'b0, 32'd0, 1'b0);
        do_fetch(32'd1, 32'hFFF08213);
        do_regs(5'd1, 5'd0, 1'b0, 1, 0, 1'b0);
        do_issue(32'd2, 1'b0, 32'd0);

        // SW x2,8(x1)
        regs[1] = 32'h100; regs[2] = 32'hAB;
        push_exp(ALU_ADD, 32'hAB, 32'd0, 1'b0, 5'd0, 1'b1, 32'h108, 1'b0);
        do_fetch(32'd2, 32'h0020A423);
        do_regs(5'd1, 5'd2, 1'b1, 1, 0, 1'b0);
        do_issue(32'd3, 1'b0, 32'd0);

        // Unlisted opcode at PC=3
        do_fetch(32'd3, 32'h0000007F);
        expect_illegal();

        // SUB x5,x6,x7, a-ack two cycles ahead of b-ack, stray ALU inputs
        regs[6] = 32'd20; regs[7] = 32'd3;
        push_exp(ALU_SUBTRACT, 32'd20, 32'd3, 1'b1, 5'd5, 1'b0, 32'd0, 1'b0);
        do_fetch(32'd4, 32'h407302B3);
        do_regs(5'd6, 5'd7, 1'b1, 0, 2, 1'b1);
        do_issue(32'd5, 1'b0, 32'd0);

        // BEQ x1,x2,+16 bytes at PC=5 -> target 5+4
        regs[1] = 32'd4; regs[2] = 32'd4;
        push_exp(ALU_BEQ, 32'd4, 32'd4, 1'b0, 5'd0, 1'b0, 32'd9, 1'b1);
        do_fetch(32'd5, 32'h00208863);
        do_regs(5'd1, 5'd2, 1'b1, 2, 1, 1'b0);
        do_issue(32'd5, 1'b1, 32'h20);

        // BNE x1,x2,-8 bytes at PC=0x20 -> target 0x1E; ALU resolves to top of space
        push_exp(ALU_BNE, 32'd4, 32'd4, 1'b0, 5'd0, 1'b0, 32'h1E, 1'b1);
        do_fetch(32'h20, 32'hFE209CE3);
        do_regs(5'd1, 5'd2, 1'b1, 0, 0, 1'b0);
        do_issue(32'h20, 1'b1, 32'hFFFF_FFFF);

        // Illegal at the top of the address space: PC wraps to 0
        do_fetch(32'hFFFF_FFFF, 32'h0000007F);
        expect_illegal();

        // R-type with unsupported funct7 (MUL) is illegal
        do_fetch(32'd0, 32'h022081B3);
        expect_illegal();

        // ADDI at PC=1, reset asserted while the issue is pending
        regs[1] = 32'd5;
        push_exp(ALU_ADD, 32'd5, 32'hFFFF_FFFF, 1'b1, 5'd4, 1'b0, 32'd0, 1'b0);
        do_fetch(32'd1, 32'hFFF08213);
        do_regs(5'd1, 5'd0, 1'b0, 0, 0, 1'b0);
        wait_for(2, "issue_before_reset");
        reset_n = 1'b0;
        #1;
        check("mid_rst_issue", {31'b0, alu_inputs_valid}, 32'd0);
        check("mid_rst_mem",   {31'b0, mem_rd_addr_valid}, 32'd0);
        check("mid_rst_rd_a",  {31'b0, reg_rd_addr_a_valid}, 32'd0);
        check("mid_rst_pc",    pc, 32'd0);
        check("mid_rst_op",    alu_op_code, ALU_ADD);
        check("mid_rst_regout", {31'b0, alu_reg_out}, 32'd0);
        void'(exp_q.pop_front());
        @(negedge clk);
        reset_n = 1'b1;

        // Refetch from 0 after release
        regs[1] = 32'd5; regs[2] = 32'd7;
        push_exp(ALU_ADD, 32'd5, 32'd7, 1'b1, 5'd3, 1'b0, 32'd0, 1'b0);
        do_fetch(32'd0, 32'h002081B3);
        do_regs(5'd1, 5'd2, 1'b1, 1, 0, 1'b0);
        do_issue(32'd1, 1'b0, 32'd0);

        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
